// File: rtl/segway_pkg.sv
// Shared types, default thresholds and helpers for the Segway alert conditioning logic.
package segway_pkg;

  typedef enum logic [0:0] {
    BATT_OK  = 1'b0,
    BATT_LOW = 1'b1
  } batt_st_t;

  localparam logic [11:0] BATT_THRESH_DEF  = 12'h800;
  localparam logic [11:0] BATT_HYST_DEF    = 12'h040;
  localparam logic [11:0] SPD_THRESH_DEF   = 12'd1536;
  localparam int unsigned BATT_PERSIST_DEF = 32'd8;
  localparam int unsigned FAST_HOLD_DEF    = 32'd25_000_000;

  // Magnitude of a 12-bit signed speed; -2048 has no positive twin so it clamps to 2047.
  function automatic logic [11:0] abs_sat(input logic signed [11:0] val);
    logic [11:0] mag_s;
    if (val == 12'sh800) begin
      mag_s = 12'd2047;
    end else if (val[11]) begin
      mag_s = 12'(-val);
    end else begin
      mag_s = 12'(val);
    end
    return mag_s;
  endfunction

  // Hold length in clocks; simulation builds shrink it by 1000 but never to zero.
  function automatic int unsigned hold_len(input int unsigned hold, input bit fast);
    int unsigned div_s;
    div_s = hold / 32'd1000;
    if (!fast) begin
      return hold;
    end else if (div_s == 32'd0) begin
      return 32'd1;
    end else begin
      return div_s;
    end
  endfunction

endpackage

// File: rtl/piezo_alert_gen_persist_filt.sv
// Consecutive-strobe persistence filter: match pulses on the N-th qualifying strobe in a row.
module persist_filt
  import segway_pkg::*;
#(
  parameter int unsigned N = BATT_PERSIST_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic vld,
  input  logic qual,
  output logic match
);

  localparam logic [7:0] N_M1 = 8'(N - 32'd1);

  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic       hit_s;

  // Strobes without qualification break the run; idle cycles leave it alone.
  always_comb begin
    hit_s = vld & qual & (cnt_r == N_M1);
    if (!vld) begin
      cnt_nxt_s = cnt_r;
    end else if (!qual || hit_s) begin
      cnt_nxt_s = 8'd0;
    end else begin
      cnt_nxt_s = cnt_r + 8'd1;
    end
  end

  // Run-length counter with synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else if (clr) begin
      cnt_r <= 8'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign match = hit_s;

endmodule

// File: rtl/piezo_alert_gen.sv
// Conditions battery, speed and steer status into stable alert requests for the piezo driver.
module piezo_alert_gen
  import segway_pkg::*;
#(
  parameter bit          fast_sim     = 1'b0,
  parameter logic [11:0] BATT_THRESH  = BATT_THRESH_DEF,
  parameter logic [11:0] BATT_HYST    = BATT_HYST_DEF,
  parameter int unsigned BATT_PERSIST = BATT_PERSIST_DEF,
  parameter logic [11:0] SPD_THRESH   = SPD_THRESH_DEF,
  parameter int unsigned FAST_HOLD    = FAST_HOLD_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwr_up,
  input  logic [11:0]         batt,
  input  logic                batt_vld,
  input  logic signed [11:0]  lft_spd,
  input  logic signed [11:0]  rght_spd,
  input  logic                spd_vld,
  input  logic                steer_en_lvl,
  output logic                batt_low,
  output logic                too_fast,
  output logic                en_steer
);

  localparam int unsigned F_W      = $clog2(FAST_HOLD + 32'd1);
  localparam int unsigned HOLD_EFF = hold_len(FAST_HOLD, fast_sim);
  localparam logic [F_W-1:0] HOLD_LD = F_W'(HOLD_EFF);
  localparam logic [F_W-1:0] F_ONE   = F_W'(32'd1);
  localparam logic [F_W-1:0] F_ZERO  = F_W'(32'd0);
  // 13-bit sum so a threshold near full scale cannot wrap the recovery level.
  localparam logic [12:0] GOOD_LVL = {1'b0, BATT_THRESH} + {1'b0, BATT_HYST};

  batt_st_t       batt_st_r;
  batt_st_t       batt_st_nxt_s;
  logic           batt_low_r;
  logic           samp_low_s;
  logic           samp_good_s;
  logic           qual_s;
  logic           match_s;
  logic           clr_s;

  logic [F_W-1:0] f_cnt_r;
  logic           too_fast_r;
  logic           over_s;

  logic           steer_q_r;
  logic           en_steer_r;

  assign clr_s = ~pwr_up;

  // Sample classification and state-dependent qualification for the filter.
  always_comb begin
    samp_low_s  = (batt < BATT_THRESH);
    samp_good_s = ({1'b0, batt} >= GOOD_LVL);
    case (batt_st_r)
      BATT_OK:  qual_s = samp_low_s;
      BATT_LOW: qual_s = samp_good_s;
      default:  qual_s = 1'b0;
    endcase
  end

  persist_filt #(
    .N(BATT_PERSIST)
  ) u_batt_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_s),
    .vld  (batt_vld),
    .qual (qual_s),
    .match(match_s)
  );

  // Battery state flips only when the filter sees a full persistent run.
  always_comb begin
    batt_st_nxt_s = batt_st_r;
    if (match_s) begin
      case (batt_st_r)
        BATT_OK:  batt_st_nxt_s = BATT_LOW;
        BATT_LOW: batt_st_nxt_s = BATT_OK;
        default:  batt_st_nxt_s = BATT_OK;
      endcase
    end else begin
      batt_st_nxt_s = batt_st_r;
    end
  end

  // Battery state and its registered level output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt_st_r  <= BATT_OK;
      batt_low_r <= 1'b0;
    end else if (!pwr_up) begin
      batt_st_r  <= BATT_OK;
      batt_low_r <= 1'b0;
    end else begin
      batt_st_r  <= batt_st_nxt_s;
      batt_low_r <= (batt_st_nxt_s == BATT_LOW);
    end
  end

  // Either wheel strictly above threshold on a valid speed sample.
  always_comb begin
    if (spd_vld) begin
      over_s = (abs_sat(lft_spd) > SPD_THRESH) | (abs_sat(rght_spd) > SPD_THRESH);
    end else begin
      over_s = 1'b0;
    end
  end

  // Retriggerable hold: too_fast drops on the clock the countdown lands on zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_cnt_r    <= F_ZERO;
      too_fast_r <= 1'b0;
    end else if (!pwr_up) begin
      f_cnt_r    <= F_ZERO;
      too_fast_r <= 1'b0;
    end else if (over_s) begin
      f_cnt_r    <= HOLD_LD;
      too_fast_r <= 1'b1;
    end else if (f_cnt_r != F_ZERO) begin
      f_cnt_r    <= f_cnt_r - F_ONE;
      too_fast_r <= (f_cnt_r != F_ONE);
    end else begin
      f_cnt_r    <= F_ZERO;
      too_fast_r <= 1'b0;
    end
  end

  // steer_q keeps tracking while powered down so power-up mid-steer stays silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steer_q_r  <= 1'b0;
      en_steer_r <= 1'b0;
    end else begin
      steer_q_r  <= steer_en_lvl;
      en_steer_r <= steer_en_lvl & ~steer_q_r & pwr_up;
    end
  end

  assign batt_low = batt_low_r;
  assign too_fast = too_fast_r;
  assign en_steer = en_steer_r;

endmodule

// File: doc/piezo_alert_gen.md
# piezo_alert_gen

Conditions the raw Segway status signals into the three alert requests consumed by the piezo driver: `en_steer`, `too_fast` and `batt_low`. The block sits between the A2D/balance-control outputs and the piezo driver. It adds persistence filtering and hysteresis to the battery comparison, a retriggerable hold on over-speed, and edge detection on steer enable. The goal is that the piezo state machine never sees chattering requests.

## Interface
- `fast_sim`, 0: when 1, `FAST_HOLD` is divided by 1000 (minimum 1)
- `BATT_THRESH`, 12'h800: battery-low threshold; a sample is low when `batt < BATT_THRESH`
- `BATT_HYST`, 12'h040: recovery margin; a sample is good when `batt >= BATT_THRESH + BATT_HYST` (13-bit sum, no wrap)
- `BATT_PERSIST`, 8: consecutive qualifying samples needed to change `batt_low` (range 1..255)
- `SPD_THRESH`, 12'd1536: over-speed when \|lft_spd\| > thr or \|rght_spd\| > thr
- `FAST_HOLD`, 25_000_000: clocks `too_fast` stays high after the last over-speed sample

Ports:
- `clk`, in, 1: clock
- `rst_n`, in, 1: reset, asynchronous, active-low
- `pwr_up`, in, 1: rider present; low synchronously clears all state
- `batt`, in, 12: unsigned battery reading
- `batt_vld`, in, 1: one-cycle strobe, `batt` valid
- `lft_spd`, in, 12 signed: left wheel speed
- `rght_spd`, in, 12 signed: right wheel speed
- `spd_vld`, in, 1: one-cycle strobe, both speeds valid
- `steer_en_lvl`, in, 1: steer-enable level
- `batt_low`, out, 1: filtered battery-low level
- `too_fast`, out, 1: held over-speed level
- `en_steer`, out, 1: one-cycle pulse on the rising edge of steer enable

## Operation
- **Battery FSM**, states `BATT_OK` and `BATT_LOW`. `batt_low` is high only in `BATT_LOW`.
  - `BATT_OK`: each `batt_vld` with a low sample increments `b_cnt`. Any `batt_vld` with a non-low sample clears `b_cnt`. When the increment would reach `BATT_PERSIST`, go to `BATT_LOW` and clear `b_cnt`.
  - `BATT_LOW`: same behaviour using good samples. A sample inside the hysteresis band clears `b_cnt`. On reaching `BATT_PERSIST`, go to `BATT_OK`.
  - Cycles without `batt_vld` leave `b_cnt` unchanged.
- **Speed path**:
  - abs() saturates: -2048 maps to 2047.
  - On `spd_vld` with over-speed: load `f_cnt` with `FAST_HOLD` and set `too_fast`.
  - Otherwise, while `f_cnt` is nonzero, decrement it. `too_fast` clears on the cycle `f_cnt` reaches 0.
  - A new over-speed sample while held reloads `f_cnt` (retrigger).
- **Steer path**:
  - `steer_en_lvl` is registered once into `steer_q`.
  - `en_steer = steer_en_lvl & ~steer_q & pwr_up`, registered.
  - A level held high produces exactly one pulse.
- **`pwr_up` low**:
  - Battery FSM goes to `BATT_OK`, and `b_cnt`, `f_cnt`, `too_fast` and `en_steer` clear.
  - `steer_q` still tracks `steer_en_lvl`, so powering up while already steering produces no pulse.
- **Simultaneous events**: `batt_vld` and `spd_vld` in the same cycle are handled independently. `pwr_up` low overrides everything.

## Timing
- All outputs are registered. Reset value of `batt_low`, `too_fast` and `en_steer` is 0. Reset value of the battery FSM is `BATT_OK`, and all counters reset to 0.
- `batt_low` rises the cycle after the `BATT_PERSIST`-th consecutive low `batt_vld`, and falls the same way.
- `too_fast` rises the cycle after the qualifying `spd_vld`. It stays high exactly `FAST_HOLD` cycles after the last qualifying `spd_vld`.
- `en_steer` is high for exactly one cycle, the cycle after the first `clk` edge that samples `steer_en_lvl` = 1.
- Reset asserted mid-hold or mid-count clears everything immediately. No output glitches on release.
- Counter widths:
  - `b_cnt` is 8 bits and never exceeds `BATT_PERSIST`.
  - `f_cnt` is `$clog2(FAST_HOLD+1)` bits.

## Structure
- Package `segway_pkg`:
  - `batt_st_t` enum (`BATT_OK`, `BATT_LOW`)
  - default thresholds `BATT_THRESH_DEF`, `BATT_HYST_DEF`, `SPD_THRESH_DEF`
- Sub-module `persist_filt`:
  - ports: `clk`, `rst_n`, `clr`, `vld`, `qual`, `match`
  - parameter `N`
  - function: counts consecutive qualifying strobes and pulses `match` on the N-th
  - the battery FSM instantiates one and muxes `qual` by state
- Speed hold and steer edge detect live in the top level.

## Test plan
- **Battery entry**: `BATT_PERSIST`=8; 7 × `batt`=12'h7F0 strobes, then 12'h900, then 8 × 12'h7F0 → `batt_low` 0 until the cycle after the final (8th) strobe of the second run.
- **Hysteresis**: in `BATT_LOW`, 8 × `batt`=12'h820 (inside band) → stays 1. Then 8 × 12'h840 → `batt_low` 0 the cycle after the 8th strobe.
- **Over-speed hold**: `fast_sim`=1, `FAST_HOLD`=25_000 (hold 25 cycles); `lft_spd`=-12'sd1600 once → `too_fast` high 25 cycles. A retrigger at cycle 20 extends high time to cycle 45.
- **Abs saturation and threshold edge**: `rght_spd`=-2048 → `too_fast`. `lft_spd`=1536 → no assertion (strict >).
- **Steer pulse**: `steer_en_lvl` held high 100 cycles → exactly one `en_steer` pulse. With `pwr_up`=0 during the rising edge → no pulse, and no pulse when `pwr_up` later rises.
- **Reset and `pwr_up`**: drop `rst_n` while `too_fast`=1 and `b_cnt`=5 → all outputs 0 immediately. After release, 3 low samples do not assert `batt_low`.
